// File: rtl/acumulador_ventana_16.sv
// acumulador_ventana_16: walks a 16:1 window mux (seleccion 0..15) and produces sum, mean and max of the 16 samples.
// Latency: 16 cycles from the edge that samples inicio to valido_salida; back-to-back windows every 17 cycles.
// Backpressure: results and valido_salida are held in ENTREGAR until aceptar; inicio is ignored meanwhile.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   inicio              start request (REPOSO, or ENTREGAR together with aceptar)
//   dato_mux            mux output for the current seleccion (combinational, same cycle)
//   seleccion           registered mux select
//   ocupado             high while accumulating
//   valido_salida       result valid, held until aceptar
//   aceptar             downstream accept
//   suma/promedio/maximo registered window results
//
// Optional build macro REDONDEO_EN: mean rounds half up ((sum+8)>>4, clamped) instead of truncating.

module acumulador_ventana_16 #(
  parameter int BITS_DATOS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inicio,
  input  logic [BITS_DATOS-1:0] dato_mux,
  output logic [3:0]            seleccion,
  output logic                  ocupado,
  output logic                  valido_salida,
  input  logic                  aceptar,
  output logic [BITS_DATOS+3:0] suma,
  output logic [BITS_DATOS-1:0] promedio,
  output logic [BITS_DATOS-1:0] maximo
);

  localparam int SW = BITS_DATOS + 4;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ACUMULAR = 2'd1,
    ENTREGAR = 2'd2
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [3:0]            seleccion_q, seleccion_d;
  logic [SW-1:0]         acum_q, acum_d;
  logic [BITS_DATOS-1:0] max_q, max_d;
  logic                  valido_q, valido_d;
  logic [SW-1:0]         suma_q, suma_d;
  logic [BITS_DATOS-1:0] promedio_q, promedio_d;
  logic [BITS_DATOS-1:0] maximo_q, maximo_d;

  // Running values including the sample on the mux this cycle.
  logic [SW-1:0]         suma_fin;
  logic [BITS_DATOS-1:0] max_fin;
  logic [BITS_DATOS-1:0] promedio_calc;

  assign suma_fin = acum_q + {4'b0000, dato_mux};
  assign max_fin  = (dato_mux > max_q) ? dato_mux : max_q;

`ifdef REDONDEO_EN
  // One extra bit so the +8 cannot wrap; the clamp can never trigger for
  // a 16-sample sum but keeps the result well defined.
  logic [SW:0] redondeo;
  logic [SW:0] desplazado;
  localparam logic [SW:0] MAX_PROM = {{5{1'b0}}, {BITS_DATOS{1'b1}}};

  always_comb begin
    redondeo      = {1'b0, suma_fin} + (SW+1)'(8);
    desplazado    = redondeo >> 4;
    promedio_calc = (desplazado > MAX_PROM) ? {BITS_DATOS{1'b1}} : desplazado[BITS_DATOS-1:0];
  end
`else
  assign promedio_calc = suma_fin[SW-1:4];
`endif

  always_comb begin
    estado_d    = estado_q;
    seleccion_d = seleccion_q;
    acum_d      = acum_q;
    max_d       = max_q;
    valido_d    = valido_q;
    suma_d      = suma_q;
    promedio_d  = promedio_q;
    maximo_d    = maximo_q;

    case (estado_q)
      REPOSO: begin
        seleccion_d = 4'd0;
        if (inicio) begin
          estado_d = ACUMULAR;
          acum_d   = '0;
          max_d    = '0;
        end
      end

      ACUMULAR: begin
        acum_d = suma_fin;
        max_d  = max_fin;
        if (seleccion_q == 4'd15) begin
          suma_d      = suma_fin;
          maximo_d    = max_fin;
          promedio_d  = promedio_calc;
          seleccion_d = 4'd0;
          valido_d    = 1'b1;
          estado_d    = ENTREGAR;
        end else begin
          seleccion_d = seleccion_q + 4'd1;
        end
      end

      ENTREGAR: begin
        if (aceptar) begin
          valido_d = 1'b0;
          if (inicio) begin
            // Restart immediately so consecutive windows have no idle gap.
            estado_d = ACUMULAR;
            acum_d   = '0;
            max_d    = '0;
          end else begin
            estado_d = REPOSO;
          end
        end
      end

      default: begin
        estado_d    = REPOSO;
        seleccion_d = 4'd0;
        valido_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado_q    <= REPOSO;
      seleccion_q <= '0;
      acum_q      <= '0;
      max_q       <= '0;
      valido_q    <= 1'b0;
      suma_q      <= '0;
      promedio_q  <= '0;
      maximo_q    <= '0;
    end else begin
      estado_q    <= estado_d;
      seleccion_q <= seleccion_d;
      acum_q      <= acum_d;
      max_q       <= max_d;
      valido_q    <= valido_d;
      suma_q      <= suma_d;
      promedio_q  <= promedio_d;
      maximo_q    <= maximo_d;
    end
  end

  assign seleccion     = seleccion_q;
  assign ocupado       = (estado_q == ACUMULAR);
  assign valido_salida = valido_q;
  assign suma          = suma_q;
  assign promedio      = promedio_q;
  assign maximo        = maximo_q;

endmodule

// File: tb/tb_acumulador_ventana_16.sv
module tb_acumulador_ventana_16;

  logic        clk;
  logic        reset_n;
  logic        inicio;
  logic [7:0]  dato_mux;
  logic [3:0]  seleccion;
  logic        ocupado;
  logic        valido_salida;
  logic        aceptar;
  logic [11:0] suma;
  logic [7:0]  promedio;
  logic [7:0]  maximo;

  int n_eval;
  int n_fail;
  int modo;

`ifdef REDONDEO_EN
  localparam int PROM_RAMPA = 8;
`else
  localparam int PROM_RAMPA = 7;
`endif

  acumulador_ventana_16 #(.BITS_DATOS(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inicio        (inicio),
    .dato_mux      (dato_mux),
    .seleccion     (seleccion),
    .ocupado       (ocupado),
    .valido_salida (valido_salida),
    .aceptar       (aceptar),
    .suma          (suma),
    .promedio      (promedio),
    .maximo        (maximo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational mux model.
  always_comb begin
    case (modo)
      0:       dato_mux = 8'd10;
      1:       dato_mux = {4'b0000, seleccion};
      2:       dato_mux = 8'd255;
      default: dato_mux = {seleccion, 4'b0001};
    endcase
  end

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input int e_suma, input int e_prom, input int e_max);
    chk("valido", int'(valido_salida), 1);
    chk("ocupado_fin", int'(ocupado), 0);
    chk("sel_fin", int'(seleccion), 0);
    chk("suma", int'(suma), e_suma);
    chk("promedio", int'(promedio), e_prom);
    chk("maximo", int'(maximo), e_max);
  endtask

  // Assumes the edge sampling inicio has just passed.
  task automatic acc_loop(input int e_suma, input int e_prom, input int e_max);
    for (int k = 0; k < 16; k++) begin
      chk("sel_paso", int'(seleccion), k);
      chk("ocupado_paso", int'(ocupado), 1);
      chk("valido_paso", int'(valido_salida), 0);
      paso();
    end
    chk_result(e_suma, e_prom, e_max);
  endtask

  task automatic ventana(input int m, input int e_suma, input int e_prom, input int e_max);
    modo   = m;
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    acc_loop(e_suma, e_prom, e_max);
  endtask

  task automatic aceptar_uno();
    aceptar = 1'b1;
    paso();
    aceptar = 1'b0;
    chk("valido_tras_aceptar", int'(valido_salida), 0);
    chk("ocupado_tras_aceptar", int'(ocupado), 0);
  endtask

  initial begin
    n_eval  = 0;
    n_fail  = 0;
    modo    = 0;
    reset_n = 1'b0;
    inicio  = 1'b0;
    aceptar = 1'b0;
    paso();
    paso();
    chk("rst_sel", int'(seleccion), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_valido", int'(valido_salida), 0);
    chk("rst_suma", int'(suma), 0);
    chk("rst_prom", int'(promedio), 0);
    chk("rst_max", int'(maximo), 0);
    reset_n = 1'b1;
    paso();
    chk("idle_ocupado", int'(ocupado), 0);

    // Constant 10.
    ventana(0, 160, 10, 10);
    aceptar_uno();
    chk("retiene_suma", int'(suma), 160);

    // Ramp 0..15.
    ventana(1, 120, PROM_RAMPA, 15);
    aceptar_uno();

    // All 255: full-scale sum without wrap.
    ventana(2, 4080, 255, 255);

    // Stall: outputs held, inicio ignored.
    for (int c = 0; c < 5; c++) begin
      inicio = (c == 2);
      paso();
      chk("stall_valido", int'(valido_salida), 1);
      chk("stall_ocupado", int'(ocupado), 0);
      chk("stall_suma", int'(suma), 4080);
      chk("stall_max", int'(maximo), 255);
    end
    inicio = 1'b0;

    // Accept and restart in the same cycle; data = {sel,4'b0001}.
    modo    = 3;
    aceptar = 1'b1;
    inicio  = 1'b1;
    paso();
    aceptar = 1'b0;
    inicio  = 1'b0;
    chk("reinicio_valido", int'(valido_salida), 0);
    acc_loop(1936, 121, 241);
    aceptar_uno();

    // Reset in mid-window at seleccion = 7.
    modo   = 0;
    inicio = 1'b1;
    paso();
    inicio = 1'b0;
    for (int k = 0; k < 7; k++) paso();
    chk("sel_antes_rst", int'(seleccion), 7);
    reset_n = 1'b0;
    paso();
    reset_n = 1'b1;
    chk("rst2_sel", int'(seleccion), 0);
    chk("rst2_ocupado", int'(ocupado), 0);
    chk("rst2_valido", int'(valido_salida), 0);
    chk("rst2_suma", int'(suma), 0);
    chk("rst2_prom", int'(promedio), 0);
    chk("rst2_max", int'(maximo), 0);
    paso();
    chk("rst2_reposo", int'(ocupado), 0);
    ventana(1, 120, PROM_RAMPA, 15);
    aceptar_uno();

    // Back-to-back windows with inicio and aceptar held high.
    modo    = 0;
    inicio  = 1'b1;
    aceptar = 1'b1;
    paso();
    for (int w = 0; w < 3; w++) begin
      acc_loop(160, 10, 10);
      paso();
      chk("b2b_valido", int'(valido_salida), 0);
      chk("b2b_ocupado", int'(ocupado), 1);
      chk("b2b_sel", int'(seleccion), 0);
    end
    inicio  = 1'b0;
    aceptar = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
